// File: rtl/codec_write_scheduler_pkg.sv
// rtl/codec_write_scheduler_pkg.sv - shared constants, register map and FSM encoding for the codec write scheduler
package codec_write_scheduler_pkg;

    localparam logic [7:0] DEVICE_ADDR = 8'h34;
    localparam int         INIT_COUNT  = 6;
    localparam int         MAX_RETRY   = 3;

    localparam logic [6:0] REG_LIN_VOL   = 7'h00;
    localparam logic [6:0] REG_RIN_VOL   = 7'h01;
    localparam logic [6:0] REG_LHP_VOL   = 7'h03;
    localparam logic [6:0] REG_AN_PATH   = 7'h04;
    localparam logic [6:0] REG_DIG_PATH  = 7'h05;
    localparam logic [6:0] REG_POWER     = 7'h06;
    localparam logic [6:0] REG_DIG_FMT   = 7'h07;
    localparam logic [6:0] REG_ACTIVE    = 7'h09;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EVAL  = 2'd3
    } state_t;

    function automatic logic [15:0] reg_entry(input logic [6:0] addr, input logic [8:0] val);
        return {addr, val};
    endfunction

endpackage

// File: rtl/codec_write_scheduler_if.sv
// rtl/codec_write_scheduler_if.sv - runtime request and I2C engine handshake bundle
interface codec_write_scheduler_if;
    logic        rtValid;
    logic [6:0]  rtReg;
    logic [8:0]  rtVal;
    logic        rtReady;
    logic        i2cStart;
    logic [23:0] i2cData;
    logic        i2cDone;
    logic        i2cAck;

    modport master (
        input  rtValid, rtReg, rtVal, i2cDone, i2cAck,
        output rtReady, i2cStart, i2cData
    );

    modport slave (
        output rtValid, rtReg, rtVal, i2cDone, i2cAck,
        input  rtReady, i2cStart, i2cData
    );
endinterface

// File: rtl/codec_init_rom.sv
// rtl/codec_init_rom.sv - boot-time codec register table, idx -> {reg, val}
module codec_init_rom
    import codec_write_scheduler_pkg::*;
(
    input  logic [3:0]  idx,
    output logic [15:0] entry
);

    always_comb begin
        entry = '0;
        case (idx)
            4'd0:    entry = reg_entry(REG_AN_PATH, 9'h004);
            4'd1:    entry = reg_entry(REG_DIG_FMT, 9'h042);
            4'd2:    entry = reg_entry(REG_ACTIVE,  9'h001);
            4'd3:    entry = reg_entry(REG_POWER,   9'h039);
            4'd4:    entry = reg_entry(REG_LIN_VOL, 9'h017);
            4'd5:    entry = reg_entry(REG_RIN_VOL, 9'h017);
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/codec_write_scheduler.sv
// rtl/codec_write_scheduler.sv - replays the init table, then serialises runtime codec writes with NACK retry
module codec_write_scheduler #(
    parameter logic [7:0] DEVICE_ADDR = codec_write_scheduler_pkg::DEVICE_ADDR,
    parameter int         INIT_COUNT  = codec_write_scheduler_pkg::INIT_COUNT,
    parameter int         MAX_RETRY   = codec_write_scheduler_pkg::MAX_RETRY
) (
    input  logic                           inClock,
    input  logic                           reset,
    codec_write_scheduler_if.master        bus,
    output logic                           initDone,
    output logic                           busy,
    output logic                           errorFlag,
    output logic [3:0]                     nackCount
);
    import codec_write_scheduler_pkg::*;

    state_t      state_q;
    logic [3:0]  init_idx_q;
    logic [2:0]  retry_q;
    logic        start_q;
    logic [23:0] word_q;
    logic        ack_q;
    logic        init_done_q;
    logic        error_q;
    logic [3:0]  nack_q;
    logic [15:0] rom_entry;
    logic        advance;

    codec_init_rom u_rom (
        .idx   (init_idx_q),
        .entry (rom_entry)
    );

    // A word is finished (sent or dropped) when EVAL sees an ACK or retries are exhausted
    assign advance = (state_q == ST_EVAL) && (ack_q || (retry_q >= 3'(MAX_RETRY)));

    assign bus.rtReady  = (state_q == ST_IDLE) && init_done_q && reset;
    assign bus.i2cStart = start_q;
    assign bus.i2cData  = word_q;
    assign initDone     = init_done_q;
    assign busy         = (state_q != ST_IDLE);
    assign errorFlag    = error_q;
    assign nackCount    = nack_q;

    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            init_idx_q  <= '0;
            retry_q     <= '0;
            start_q     <= 1'b0;
            word_q      <= '0;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            nack_q      <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!init_done_q) begin
                        word_q  <= {DEVICE_ADDR, rom_entry};
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end else if (bus.rtValid) begin
                        word_q  <= {DEVICE_ADDR, bus.rtReg, bus.rtVal};
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (bus.i2cDone) begin
                        ack_q   <= bus.i2cAck;
                        state_q <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (ack_q) begin
                        retry_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        if (nack_q != 4'hF) nack_q <= nack_q + 4'd1;
                        if (retry_q < 3'(MAX_RETRY)) begin
                            retry_q <= retry_q + 3'd1;
                            start_q <= 1'b1;
                            state_q <= ST_ISSUE;
                        end else begin
                            error_q <= 1'b1;
                            retry_q <= '0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Runtime words leave the init counters untouched
            if (advance && !init_done_q) begin
                init_idx_q <= init_idx_q + 4'd1;
                if (init_idx_q == 4'(INIT_COUNT - 1)) init_done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_codec_write_scheduler.sv
// tb/tb_codec_write_scheduler.sv - scoreboard bench with I2C engine model for codec_write_scheduler
module tb_codec_write_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_done, busy, error_flag;
    logic [3:0] nack_count;

    codec_write_scheduler_if bus ();

    codec_write_scheduler dut (
        .inClock   (clk),
        .reset     (rst_n),
        .bus       (bus),
        .initDone  (init_done),
        .busy      (busy),
        .errorFlag (error_flag),
        .nackCount (nack_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int starts = 0;
    logic [23:0] exp_q[$];
    logic        ack_q[$];
    logic [23:0] init_words [6] = '{24'h340804, 24'h340E42, 24'h341201,
                                     24'h340C39, 24'h340017, 24'h340217};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse must match the next expected word
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.i2cStart === 1'b1) begin
                starts++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_start: got 0x%0h expected no transfer", bus.i2cData);
                end else begin
                    check("i2c_word", bus.i2cData, exp_q.pop_front());
                end
            end
        end
    end

    // Engine model: done three cycles after start, ack taken from script (default ACK)
    initial begin
        int eng_cnt;
        eng_cnt = 0;
        bus.i2cDone = 1'b0;
        bus.i2cAck  = 1'b0;
        forever begin
            @(negedge clk);
            bus.i2cDone = 1'b0;
            if (!rst_n) begin
                eng_cnt = 0;
            end else if (eng_cnt != 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.i2cDone = 1'b1;
                    bus.i2cAck  = (ack_q.size() != 0) ? ack_q.pop_front() : 1'b1;
                end
            end else if (bus.i2cStart === 1'b1) begin
                eng_cnt = 3;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.rtValid = 1'b0;
        exp_q.delete();
        ack_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic push_init();
        foreach (init_words[i]) exp_q.push_back(init_words[i]);
    endtask

    task automatic wait_init(input int budget);
        int n;
        n = 0;
        while (!init_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("init_done_reached", init_done, 1);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int n;
        bus.rtValid = 1'b0;
        bus.rtReg   = '0;
        bus.rtVal   = '0;

        // Reset state
        do_reset();
        check("rst_start", bus.i2cStart, 0);
        check("rst_data", bus.i2cData, 0);
        check("rst_init_done", init_done, 0);
        check("rst_error", error_flag, 0);
        check("rst_nack", nack_count, 0);
        check("rst_busy", busy, 0);
        check("rst_rt_ready", bus.rtReady, 0);

        // Clean init, all ACK
        push_init();
        base = starts;
        rst_n = 1'b1;
        wait_init(400);
        check("t1_starts", starts - base, 6);
        check("t1_nack", nack_count, 0);
        check("t1_error", error_flag, 0);
        check("t1_rt_ready", bus.rtReady, 1);

        // Runtime write after init
        exp_q.push_back(24'h340679);
        bus.rtReg   = 7'h03;
        bus.rtVal   = 9'h079;
        bus.rtValid = 1'b1;
        @(negedge clk);
        bus.rtValid = 1'b0;
        check("t2_start_latency", bus.i2cStart, 1);
        check("t2_data", bus.i2cData, 24'h340679);
        check("t2_rt_ready_busy", bus.rtReady, 0);
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!bus.i2cDone && n < 50);
        check("t2_done_seen", bus.i2cDone, 1);
        #1;
        check("t2_rt_ready_done", bus.rtReady, 0);
        check("t2_data_held", bus.i2cData, 24'h340679);
        @(posedge clk);
        #1;
        check("t2_rt_ready_after", bus.rtReady, 1);
        repeat (2) @(negedge clk);
        check("t2_queue", exp_q.size(), 0);

        // Two NACKs on the second init word, then ACK
        do_reset();
        exp_q.push_back(init_words[0]);
        repeat (3) exp_q.push_back(init_words[1]);
        for (int i = 2; i < 6; i++) exp_q.push_back(init_words[i]);
        ack_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        base = starts;
        rst_n = 1'b1;
        wait_init(600);
        check("t3_starts", starts - base, 8);
        check("t3_nack", nack_count, 2);
        check("t3_error", error_flag, 0);

        // Second word always NACKed: dropped after MAX_RETRY re-issues
        do_reset();
        exp_q.push_back(init_words[0]);
        repeat (4) exp_q.push_back(init_words[1]);
        for (int i = 2; i < 6; i++) exp_q.push_back(init_words[i]);
        ack_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        base = starts;
        rst_n = 1'b1;
        wait_init(600);
        check("t4_starts", starts - base, 9);
        check("t4_nack", nack_count, 4);
        check("t4_error", error_flag, 1);

        // Runtime request held from reset waits behind the whole init table
        do_reset();
        push_init();
        exp_q.push_back(24'h340A08);
        bus.rtReg   = 7'h05;
        bus.rtVal   = 9'h008;
        bus.rtValid = 1'b1;
        base = starts;
        rst_n = 1'b1;
        n = 0;
        while (bus.rtReady !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t5_ready_after_init", init_done, 1);
        check("t5_init_words_first", exp_q.size(), 1);
        @(negedge clk);
        bus.rtValid = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_queue", exp_q.size(), 0);
        check("t5_starts", starts - base, 7);

        // Reset during WAIT of the third init word
        do_reset();
        push_init();
        base = starts;
        rst_n = 1'b1;
        n = 0;
        while (starts - base < 3 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        check("t6_wait_busy", busy, 1);
        check("t6_wait_data", bus.i2cData, 24'h341201);
        rst_n = 1'b0;
        #1;
        check("t6_rst_start", bus.i2cStart, 0);
        check("t6_rst_init_done", init_done, 0);
        check("t6_rst_data", bus.i2cData, 0);
        exp_q.delete();
        ack_q.delete();
        push_init();
        repeat (2) @(negedge clk);
        base = starts;
        rst_n = 1'b1;
        wait_init(400);
        check("t6_restart_starts", starts - base, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
